// File: rtl/output_pool_compare.sv
// Lane-parallel max-pool: ping-pong window banks, optional ReLU,
// 2-entry output queue drained by valid/ready.
module output_pool_compare #(
  parameter int DATA_W = 8,
  parameter int LANES  = 6
) (
  input  logic                    CLK,
  input  logic                    RSTL,
  input  logic                    O_COMPARE_EN,
  input  logic                    O_COMPARE_MODE,
  input  logic                    O_COMPARE_REGEN,
  input  logic                    O_COMPARE_SWITCH,
  input  logic                    RELU_EN,
  input  logic [LANES*DATA_W-1:0] DIN,
  input  logic                    DOUT_READY,
  output logic [LANES*DATA_W-1:0] DOUT,
  output logic                    DOUT_VALID,
  output logic                    POOL_BUSY,
  output logic                    OVERFLOW
);

  localparam int W = LANES * DATA_W;

  logic [W-1:0] bank [2];
  logic [3:0]   cnt  [2];
  logic [W-1:0] q    [2];
  logic         head;
  logic         tail;
  logic [1:0]   occ;
  logic         ovf;

  logic         s;
  logic [W-1:0] cur;
  logic [3:0]   c;
  logic [W-1:0] m;
  logic [W-1:0] pv;
  logic [3:0]   ncnt;
  logic         load;
  logic         do_push;
  logic         pop;
  logic         accept;

  assign s = O_COMPARE_SWITCH;

  // m is the bank value after this cycle's update, so a
  // same-cycle REGEN includes the current DIN.
  always_comb begin
    cur     = bank[s];
    c       = cnt[s];
    m       = cur;
    pv      = '0;
    ncnt    = c;
    load    = O_COMPARE_EN && (!O_COMPARE_MODE || c == 4'd0);
    for (int i = 0; i < LANES; i++) begin
      if (load) begin
        m[i*DATA_W +: DATA_W] = DIN[i*DATA_W +: DATA_W];
      end else if (O_COMPARE_EN &&
          $signed(DIN[i*DATA_W +: DATA_W]) >
          $signed(cur[i*DATA_W +: DATA_W])) begin
        m[i*DATA_W +: DATA_W] = DIN[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (RELU_EN && m[i*DATA_W + DATA_W - 1])
        pv[i*DATA_W +: DATA_W] = '0;
      else
        pv[i*DATA_W +: DATA_W] = m[i*DATA_W +: DATA_W];
    end
    if (load)
      ncnt = 4'd1;
    else if (O_COMPARE_EN && c != 4'd15)
      ncnt = c + 4'd1;
    do_push = O_COMPARE_REGEN && (c != 4'd0 || O_COMPARE_EN);
    if (do_push)
      ncnt = 4'd0;
    pop    = (occ != 2'd0) && DOUT_READY;
    accept = do_push && (occ != 2'd2 || pop);
  end

  always_ff @(posedge CLK) begin
    if (RSTL) begin
      for (int b = 0; b < 2; b++) begin
        bank[b] <= '0;
        cnt[b]  <= '0;
        q[b]    <= '0;
      end
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
      ovf  <= 1'b0;
    end else begin
      if (O_COMPARE_EN)
        bank[s] <= m;
      cnt[s] <= ncnt;
      if (accept) begin
        q[tail] <= pv;
        tail    <= ~tail;
      end
      if (pop)
        head <= ~head;
      if (accept && !pop)
        occ <= occ + 2'd1;
      else if (!accept && pop)
        occ <= occ - 2'd1;
      if (do_push && !accept)
        ovf <= 1'b1;
    end
  end

  assign DOUT       = q[head];
  assign DOUT_VALID = (occ != 2'd0);
  assign POOL_BUSY  = (cnt[0] != 4'd0) || (cnt[1] != 4'd0) ||
                      (occ != 2'd0);
  assign OVERFLOW   = ovf;

endmodule

// File: tb/tb_output_pool_compare.sv
// Scoreboard bench for output_pool_compare: directed windows,
// expected pool results queued at issue, checked on handshake.
module tb_output_pool_compare;

  localparam int DW = 8;
  localparam int L  = 6;
  localparam int W  = DW * L;

  logic         clk = 1'b0;
  logic         rstl;
  logic         en;
  logic         mode;
  logic         regen;
  logic         sw;
  logic         relu;
  logic [W-1:0] din;
  logic         ready;
  logic [W-1:0] dout;
  logic         dvalid;
  logic         busy;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] sb [$];

  always #5 clk = ~clk;

  output_pool_compare dut (
    .CLK(clk),
    .RSTL(rstl),
    .O_COMPARE_EN(en),
    .O_COMPARE_MODE(mode),
    .O_COMPARE_REGEN(regen),
    .O_COMPARE_SWITCH(sw),
    .RELU_EN(relu),
    .DIN(din),
    .DOUT_READY(ready),
    .DOUT(dout),
    .DOUT_VALID(dvalid),
    .POOL_BUSY(busy),
    .OVERFLOW(ovf)
  );

  function automatic logic [W-1:0] pk(
    input int a, input int b, input int c,
    input int d, input int e, input int f);
    logic [W-1:0] v;
    v[0*DW +: DW] = a[7:0];
    v[1*DW +: DW] = b[7:0];
    v[2*DW +: DW] = c[7:0];
    v[3*DW +: DW] = d[7:0];
    v[4*DW +: DW] = e[7:0];
    v[5*DW +: DW] = f[7:0];
    return v;
  endfunction

  function automatic logic [W-1:0] all(input int a);
    return pk(a, a, a, a, a, a);
  endfunction

  // monitor: pops the scoreboard on every accepted handshake
  always @(negedge clk) begin
    if (!rstl && dvalid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out got=%h", dout);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL dout got=%h want=%h", dout, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [W-1:0] g,
                     input logic [W-1:0] w);
    checks++;
    if (g !== w) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, g, w);
    end
  endtask

  task automatic cyc(input logic e, input logic md,
                     input logic rg, input logic [W-1:0] d);
    en = e; mode = md; regen = rg; din = d;
    @(posedge clk); #1;
    en = 0; mode = 0; regen = 0; din = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain;
    int k;
    k = 0;
    while ((sb.size() != 0 || dvalid) && k < 20) begin
      @(posedge clk); #1; k++;
    end
    checks++;
    if (sb.size() != 0 || dvalid) begin
      failures++;
      $display("FAIL drain got_left=%0d want=0", sb.size());
    end
  endtask

  task automatic do_reset;
    rstl = 1;
    idle(1);
    rstl = 0;
  endtask

  initial begin
    rstl = 1; en = 0; mode = 0; regen = 0; sw = 0;
    relu = 0; din = '0; ready = 1;
    idle(2);
    rstl = 0;
    chk("rst_dout", dout, '0);
    chk("rst_valid", W'(dvalid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));

    // 2x2 window, no ReLU
    cyc(1, 0, 0, pk(5, -3, 0, 0, 0, 0));
    cyc(1, 1, 0, pk(7, -8, 0, 0, 0, 0));
    cyc(1, 1, 0, pk(2, -1, 0, 0, 0, 0));
    sb.push_back(pk(7, -1, 0, 0, 0, 0));
    cyc(1, 1, 1, pk(1, -2, 0, 0, 0, 0));
    chk("win_valid", W'(dvalid), W'(1));
    idle(1);
    chk("win_valid_1cyc", W'(dvalid), W'(0));
    chk("win_busy_low", W'(busy), W'(0));

    // same window with ReLU
    relu = 1;
    cyc(1, 0, 0, pk(5, -3, 0, 0, 0, 0));
    cyc(1, 1, 0, pk(7, -8, 0, 0, 0, 0));
    cyc(1, 1, 0, pk(2, -1, 0, 0, 0, 0));
    sb.push_back(pk(7, 0, 0, 0, 0, 0));
    cyc(1, 1, 1, pk(1, -2, 0, 0, 0, 0));
    drain();
    relu = 0;

    // signed extremes and equal values
    cyc(1, 0, 0, pk(-128, 127, -128, 3, -1, 0));
    sb.push_back(pk(127, 127, -127, 3, -1, 1));
    cyc(1, 1, 1, pk(127, -128, -127, 3, -2, 1));
    drain();

    // ping-pong
    sw = 0; cyc(1, 0, 0, all(10));
    sw = 1; cyc(1, 0, 0, all(20));
    sb.push_back(all(25));
    cyc(1, 1, 1, all(25));
    sw = 0;
    sb.push_back(all(12));
    cyc(1, 1, 1, all(12));
    drain();
    chk("pp_busy", W'(busy), W'(0));

    // backpressure / overflow
    ready = 0;
    sb.push_back(all(1)); cyc(1, 0, 1, all(1));
    sb.push_back(all(2)); cyc(1, 0, 1, all(2));
    chk("bp_ovf_pre", W'(ovf), W'(0));
    cyc(1, 0, 1, all(3));
    chk("bp_ovf", W'(ovf), W'(1));
    chk("bp_head", dout, all(1));
    chk("bp_valid", W'(dvalid), W'(1));
    idle(2);
    chk("bp_stable", dout, all(1));
    ready = 1;
    drain();
    chk("bp_ovf_sticky", W'(ovf), W'(1));

    // simultaneous push and pop on a full queue
    do_reset();
    chk("sim_ovf_clr", W'(ovf), W'(0));
    ready = 0;
    sb.push_back(all(4)); cyc(1, 0, 1, all(4));
    sb.push_back(all(5)); cyc(1, 0, 1, all(5));
    ready = 1;
    sb.push_back(all(6)); cyc(1, 0, 1, all(6));
    chk("sim_ovf", W'(ovf), W'(0));
    drain();

    // reset mid-window
    cyc(1, 1, 0, all(9));
    cyc(1, 1, 0, all(8));
    chk("rm_busy_pre", W'(busy), W'(1));
    do_reset();
    cyc(0, 0, 1, '0);
    chk("rm_valid", W'(dvalid), W'(0));
    chk("rm_busy", W'(busy), W'(0));
    idle(2);
    chk("rm_valid2", W'(dvalid), W'(0));
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_left got=%0d want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=done");
    $fatal(1, "timeout");
  end

endmodule
